// File: rtl/irq_controller.sv
// External interrupt front end for coprocessor 0: synchronise, detect, mask, prioritise, request.
// Optional glitch filter on every synchronised line: define IRQ_CONTROLLER_GLITCH_FILTER_EN.
module irq_controller #(
  parameter int unsigned N_IRQ       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MASK_ADDR   = 4,
  parameter int unsigned PEND_ADDR   = 5,
  parameter int unsigned EDGE_ADDR   = 6,
  parameter int unsigned ID_ADDR     = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_exeption,
  input  logic             i_eret,
  input  logic             i_we,
  input  logic [4:0]       i_address,
  input  logic [31:0]      i_data,
  output logic [31:0]      o_data,
  output logic             o_external_interrupt,
  output logic [4:0]       o_irq_id
);

  localparam int unsigned ID_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] line_c;
  logic [N_IRQ-1:0] line_d_q;
  logic [N_IRQ-1:0] rise_c;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] pend_d_c;
  logic [N_IRQ-1:0] mask_q;
  logic [N_IRQ-1:0] edge_sel_q;
  logic [N_IRQ-1:0] active_c;
  logic [N_IRQ-1:0] clr_c;
  logic [N_IRQ-1:0] edge_next_c;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  winner_c;
  logic             accept_c;
  logic             wr_mask_c;
  logic             wr_pend_c;
  logic             wr_edge_c;
  logic             data_unused;

  // Upper write-data bits are ignored when N_IRQ < 32.
  assign data_unused = ^i_data;

  // Per-line synchroniser chain; the last stage is the synchronised line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= i_irq;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

`ifdef IRQ_CONTROLLER_GLITCH_FILTER_EN
  // Filtered value follows the line only when the last three synchronised samples agree.
  logic [N_IRQ-1:0] hist_q;
  logic [N_IRQ-1:0] filt_q;
  logic [N_IRQ-1:0] agree_c;

  assign agree_c = ~(sync_q[SYNC_STAGES-2] ^ sync_q[SYNC_STAGES-1]) &
                   ~(sync_q[SYNC_STAGES-1] ^ hist_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q <= '0;
      filt_q <= '0;
    end else begin
      hist_q <= sync_q[SYNC_STAGES-1];
      filt_q <= (filt_q & ~agree_c) | (sync_q[SYNC_STAGES-1] & agree_c);
    end
  end

  assign line_c = filt_q;
`else
  assign line_c = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) line_d_q <= '0;
    else          line_d_q <= line_c;
  end

  assign rise_c    = line_c & ~line_d_q;
  assign wr_mask_c = i_we && (i_address == ID_W'(MASK_ADDR));
  assign wr_pend_c = i_we && (i_address == ID_W'(PEND_ADDR));
  assign wr_edge_c = i_we && (i_address == ID_W'(EDGE_ADDR));
  assign active_c  = pend_q & mask_q;
  assign accept_c  = (state_q == REQUEST) && i_exeption && (|active_c);

  // Fixed priority: lowest index wins.
  always_comb begin
    logic found;
    winner_c = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (active_c[i] && !found) begin
        winner_c = ID_W'(i);
        found    = 1'b1;
      end
    end
  end

  // Edge lines: set beats write-1-clear and accept-clear. Level lines track the line.
  always_comb begin
    clr_c = '0;
    if (wr_pend_c) clr_c = i_data[N_IRQ-1:0];
    if (accept_c)  clr_c = clr_c | (N_IRQ'(1) << o_irq_id);
    edge_next_c = rise_c | (pend_q & ~clr_c);
    pend_d_c    = (edge_sel_q & edge_next_c) | (~edge_sel_q & line_c);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q     <= '0;
      mask_q     <= '0;
      edge_sel_q <= '1;
    end else begin
      pend_q <= pend_d_c;
      if (wr_mask_c) mask_q     <= i_data[N_IRQ-1:0];
      if (wr_edge_c) edge_sel_q <= i_data[N_IRQ-1:0];
    end
  end

  // Request handshake with the exception unit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q              <= IDLE;
      o_external_interrupt <= 1'b0;
      o_irq_id             <= '0;
      id_q                 <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|active_c) begin
            state_q              <= REQUEST;
            o_external_interrupt <= 1'b1;
            o_irq_id             <= winner_c;
          end
        end
        REQUEST: begin
          if (!(|active_c)) begin
            state_q              <= IDLE;
            o_external_interrupt <= 1'b0;
          end else if (i_exeption) begin
            state_q              <= SERVICE;
            o_external_interrupt <= 1'b0;
            id_q                 <= o_irq_id;
          end else begin
            o_irq_id <= winner_c;
          end
        end
        SERVICE: begin
          if (i_eret) state_q <= IDLE;
        end
        default: begin
          state_q              <= IDLE;
          o_external_interrupt <= 1'b0;
        end
      endcase
    end
  end

  // Combinational register read, zero-extended.
  always_comb begin
    o_data = '0;
    if      (i_address == ID_W'(MASK_ADDR)) o_data = DATA_W'(mask_q);
    else if (i_address == ID_W'(PEND_ADDR)) o_data = DATA_W'(pend_q);
    else if (i_address == ID_W'(EDGE_ADDR)) o_data = DATA_W'(edge_sel_q);
    else if (i_address == ID_W'(ID_ADDR))   o_data = DATA_W'(id_q);
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expectations queued at stimulus, popped at observation.
module tb_irq_controller;

  localparam int unsigned N_IRQ = 8;
`ifdef IRQ_CONTROLLER_GLITCH_FILTER_EN
  localparam int LAT = 5;
  localparam int PW  = 3;
`else
  localparam int LAT = 3;
  localparam int PW  = 1;
`endif
  localparam logic [4:0] A_MASK = 5'd4;
  localparam logic [4:0] A_PEND = 5'd5;
  localparam logic [4:0] A_EDGE = 5'd6;
  localparam logic [4:0] A_ID   = 5'd7;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [N_IRQ-1:0] i_irq = '0;
  logic             i_exeption = 1'b0;
  logic             i_eret = 1'b0;
  logic             i_we = 1'b0;
  logic [4:0]       i_address = '0;
  logic [31:0]      i_data = '0;
  logic [31:0]      o_data;
  logic             o_external_interrupt;
  logic [4:0]       o_irq_id;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] rdata;

  irq_controller dut (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_irq                (i_irq),
    .i_exeption           (i_exeption),
    .i_eret               (i_eret),
    .i_we                 (i_we),
    .i_address            (i_address),
    .i_data               (i_data),
    .o_data               (o_data),
    .o_external_interrupt (o_external_interrupt),
    .o_irq_id             (o_irq_id)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
    else check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    i_address = a;
    #1;
    d = o_data;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    i_we = 1'b1; i_address = a; i_data = d;
    step(1);
    i_we = 1'b0; i_data = '0;
  endtask

  // Raw pulse of PW clocks; returns just after its last sampling edge.
  task automatic pulse(input logic [N_IRQ-1:0] lines);
    i_irq = lines;
    step(PW);
    i_irq = '0;
  endtask

  task automatic accept();
    i_exeption = 1'b1;
    step(1);
    i_exeption = 1'b0;
  endtask

  task automatic eret();
    i_eret = 1'b1;
    step(1);
    i_eret = 1'b0;
  endtask

  initial begin
    // Reset values
    step(2);
    i_rst_n = 1'b1;
    sb_push("rst_ext", 32'd0); sb_push("rst_id", 32'd0); sb_push("rst_mask", 32'd0);
    sb_push("rst_edge", 32'hFF); sb_push("rst_pend", 32'd0);
    step(1);
    sb_pop(32'(o_external_interrupt)); sb_pop(32'(o_irq_id));
    rd(A_MASK, rdata); sb_pop(rdata);
    rd(A_EDGE, rdata); sb_pop(rdata);
    rd(A_PEND, rdata); sb_pop(rdata);

    // Single edge on line 0: latency, request, accept, eret
    wr(A_MASK, 32'h01);
    sb_push("t1_pend_early", 32'h00); sb_push("t1_pend", 32'h01); sb_push("t1_ext_early", 32'd0);
    sb_push("t1_ext", 32'd1); sb_push("t1_id", 32'd0);
    pulse(8'h01);
    step(LAT - PW - 1);
    rd(A_PEND, rdata); sb_pop(rdata);
    step(1);
    rd(A_PEND, rdata); sb_pop(rdata); sb_pop(32'(o_external_interrupt));
    step(1);
    sb_pop(32'(o_external_interrupt)); sb_pop(32'(o_irq_id));
    sb_push("t1_acc_pend", 32'h00); sb_push("t1_acc_ext", 32'd0); sb_push("t1_svc_ext", 32'd0);
    sb_push("t1_eret_ext", 32'd0); sb_push("t1_idle_ext", 32'd0);
    accept();
    rd(A_PEND, rdata); sb_pop(rdata); sb_pop(32'(o_external_interrupt));
    step(2);
    sb_pop(32'(o_external_interrupt));
    eret();
    sb_pop(32'(o_external_interrupt));
    step(1);
    sb_pop(32'(o_external_interrupt));

    // Lines 5 and 2 together: 2 wins, then 5 after eret
    wr(A_MASK, 32'hFF);
    sb_push("t2_ext", 32'd1); sb_push("t2_id", 32'd2); sb_push("t2_acc_pend", 32'h20);
    sb_push("t2_latched_id", 32'd2); sb_push("t2_id_wr_ignored", 32'd2); sb_push("t2_bad_addr", 32'd0);
    sb_push("t2_rereq_ext", 32'd1); sb_push("t2_rereq_id", 32'd5);
    pulse(8'h24);
    step(LAT - PW + 1);
    sb_pop(32'(o_external_interrupt)); sb_pop(32'(o_irq_id));
    accept();
    rd(A_PEND, rdata); sb_pop(rdata);
    rd(A_ID, rdata); sb_pop(rdata);
    wr(A_ID, 32'h1F);
    rd(A_ID, rdata); sb_pop(rdata);
    rd(5'd9, rdata); sb_pop(rdata);
    eret();
    step(1);
    sb_pop(32'(o_external_interrupt)); sb_pop(32'(o_irq_id));
    accept();
    eret();

    // Level mode on line 3: request, then drop before accept
    wr(A_MASK, 32'h08);
    wr(A_EDGE, 32'h00);
    sb_push("t3_lvl_ext", 32'd1); sb_push("t3_lvl_id", 32'd3);
    sb_push("t3_drop_ext", 32'd0); sb_push("t3_drop_pend", 32'h00);
    i_irq = 8'h08;
    step(LAT + 1);
    sb_pop(32'(o_external_interrupt)); sb_pop(32'(o_irq_id));
    i_irq = '0;
    step(LAT + 1);
    sb_pop(32'(o_external_interrupt));
    rd(A_PEND, rdata); sb_pop(rdata);
    wr(A_EDGE, 32'hFF);

    // Clear and new edge on line 1 in the same cycle: set wins; a lone clear then drops the request
    wr(A_MASK, 32'h02);
    sb_push("t4_req_ext", 32'd1); sb_push("t4_req_id", 32'd1);
    sb_push("t4_set_wins", 32'h02); sb_push("t4_clr_pend", 32'h00); sb_push("t4_clr_ext", 32'd0);
    pulse(8'h02);
    step(LAT - PW + 1);
    sb_pop(32'(o_external_interrupt)); sb_pop(32'(o_irq_id));
    pulse(8'h02);
    step(LAT - PW - 1);
    wr(A_PEND, 32'h02);
    rd(A_PEND, rdata); sb_pop(rdata);
    wr(A_PEND, 32'h02);
    rd(A_PEND, rdata); sb_pop(rdata);
    step(1);
    sb_pop(32'(o_external_interrupt));

    // Edge during SERVICE is held until eret; reset mid-REQUEST
    wr(A_MASK, 32'h10);
    sb_push("t5_req_id", 32'd4); sb_push("t5_svc_pend", 32'h10); sb_push("t5_svc_ext", 32'd0);
    sb_push("t5_eret_ext", 32'd0); sb_push("t5_rereq_ext", 32'd1); sb_push("t5_rereq_id", 32'd4);
    pulse(8'h10);
    step(LAT - PW + 1);
    sb_pop(32'(o_irq_id));
    accept();
    pulse(8'h10);
    step(LAT - PW);
    rd(A_PEND, rdata); sb_pop(rdata);
    step(2);
    sb_pop(32'(o_external_interrupt));
    eret();
    sb_pop(32'(o_external_interrupt));
    step(1);
    sb_pop(32'(o_external_interrupt)); sb_pop(32'(o_irq_id));
    sb_push("t5_rst_ext", 32'd0); sb_push("t5_rst_id", 32'd0);
    sb_push("t5_rst_pend", 32'h00); sb_push("t5_rst_mask", 32'h00);
    i_rst_n = 1'b0;
    #1;
    sb_pop(32'(o_external_interrupt)); sb_pop(32'(o_irq_id));
    rd(A_PEND, rdata); sb_pop(rdata);
    rd(A_MASK, rdata); sb_pop(rdata);
    step(1);
    i_rst_n = 1'b1;
    step(1);

`ifdef IRQ_CONTROLLER_GLITCH_FILTER_EN
    // Short pulse is discarded; a 4-clock pulse lands after 5 clocks
    wr(A_MASK, 32'h01);
    sb_push("gf_short_pend", 32'h00); sb_push("gf_long_early", 32'h00); sb_push("gf_long_pend", 32'h01);
    i_irq = 8'h01;
    step(2);
    i_irq = '0;
    step(8);
    rd(A_PEND, rdata); sb_pop(rdata);
    i_irq = 8'h01;
    step(4);
    i_irq = '0;
    rd(A_PEND, rdata); sb_pop(rdata);
    step(1);
    rd(A_PEND, rdata); sb_pop(rdata);
`endif

    if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- External interrupt front end that sits directly upstream of the coprocessor-0 exception block and drives its external-interrupt request input.
- Synchronises N asynchronous interrupt lines and detects edges or levels per line. Holds pending and mask registers and priority-encodes the active lines.
- Holds a single request high until the exception unit accepts it, then stays in service until the handler returns with ERET.
- Registers are accessed through the same mtc0-style address/data bus used for the coprocessor-0 registers.

Parameters:
- N_IRQ, 8, number of external interrupt lines (1..32).
- SYNC_STAGES, 2, flip-flop synchroniser depth per line (>=2).
- MASK_ADDR, 4, register address of MASK (1 = line enabled).
- PEND_ADDR, 5, register address of PENDING (read; write-1-to-clear).
- EDGE_ADDR, 6, register address of EDGE_SEL (1 = rising-edge, 0 = level).
- ID_ADDR, 7, register address of the read-only latched ID of the line in service.

Ports:
- i_clk  in  1  system clock, rising-edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_irq  in  N_IRQ  raw asynchronous interrupt lines, active-high.
- i_exeption  in  1  exception-taken pulse from coprocessor 0; acts as the accept.
- i_eret  in  1  return-from-exception pulse.
- i_we  in  1  register write strobe (mtc0).
- i_address  in  5  register address.
- i_data  in  32  write data.
- o_data  out  32  combinational read data.
- o_external_interrupt  out  1  registered request to coprocessor 0.
- o_irq_id  out  5  registered index of the highest-priority requesting line.

Behaviour:
- Reset values:
  - All synchroniser flops 0; PENDING 0; MASK 0; EDGE_SEL all-ones (N_IRQ bits); ID 0.
  - State IDLE; o_external_interrupt 0; o_irq_id 0.
- Synchroniser: s[i] is the last stage of the chain. The edge flop holds s delayed by one cycle. A rising edge is s & ~s_d.
- PENDING[i] next value:
  - Edge mode: set on a detected rising edge; cleared by a write-1 to PEND_ADDR, or by acceptance of line i.
  - Set beats clear in the same cycle.
  - Level mode: PENDING[i] = s[i] each cycle. Writes and acceptance have no effect.
- Latency:
  - A raw edge appears in PENDING after SYNC_STAGES+1 clocks.
  - o_external_interrupt rises 1 clock later (registered).
- active = PENDING & MASK. Priority is fixed; the lowest index wins.
- States:
  - IDLE: if active != 0, go to REQUEST; register o_external_interrupt=1 and o_irq_id = winner index.
  - REQUEST:
    - Keep o_irq_id tracking the current winner each cycle.
    - If active becomes 0 (mask write, clear, or level drop) before acceptance: go to IDLE, o_external_interrupt=0, o_irq_id unchanged.
    - On i_exeption: latch ID = o_irq_id, clear PENDING[o_irq_id] if that line is edge-mode, drop o_external_interrupt, go to SERVICE.
  - SERVICE:
    - o_external_interrupt held 0; new edges accumulate in PENDING.
    - On i_eret: go to IDLE. A re-request can rise no earlier than the cycle after.
- i_exeption while in IDLE or SERVICE is ignored; coprocessor 0 may raise exceptions for other causes.
- Reading and writing registers:
  - Reads are combinational by i_address, zero-extended to 32 bits; unknown addresses read 0.
  - Writes to MASK and EDGE_SEL take effect on the next clock and use bits [N_IRQ-1:0] only.
  - Writes to ID_ADDR are ignored.
- Switching EDGE_SEL from level to edge does not clear PENDING; the next cycle applies edge rules to the held value.
- Simultaneous i_eret and a rising edge: the edge is captured in PENDING; the FSM goes to IDLE and re-requests one clock later.
- Reset mid-operation: everything returns to its reset values at once; in-flight edges are lost.

Optional Feature:
- Macro: IRQ_CONTROLLER_GLITCH_FILTER_EN.
- When defined: a synchronised line must hold the same value for 3 consecutive clocks before the filtered value updates. Edge detection and level mode use the filtered value. Latency grows by 2 clocks. Pulses shorter than 3 clocks are discarded.
- When undefined: the synchroniser output is used directly, with the latency given above.

Test Plan:
- Reset, MASK=0x01, EDGE_SEL=0xFF; 1-clock raw pulse on i_irq[0] -> PENDING=0x01 after 3 clocks; o_external_interrupt=1 and o_irq_id=0 one clock later; i_exeption -> PENDING=0x00, ID=0, state SERVICE; i_eret -> IDLE, output stays 0.
- MASK=0xFF; edges on lines 5 and 2 in the same cycle -> o_irq_id=2. After accept and eret -> re-request with o_irq_id=5.
- MASK=0x08, EDGE_SEL=0x00; hold i_irq[3]=1 -> request. Deassert i_irq[3] before any i_exeption -> o_external_interrupt returns to 0, PENDING=0x00.
- In REQUEST for line 1: write PEND_ADDR data 0x02 in the same cycle a new edge on line 1 is detected -> PENDING[1] stays 1.
- In SERVICE, edge on line 4 (MASK=0x10) -> PENDING=0x10, no request until i_eret; request rises the clock after eret. Assert i_rst_n=0 mid-REQUEST -> all outputs 0 immediately.
- With IRQ_CONTROLLER_GLITCH_FILTER_EN: a 2-clock pulse on i_irq[0] (MASK=0x01) -> PENDING stays 0. A 4-clock pulse -> PENDING=0x01 after 5 clocks.
